mcpu_mem_wrr_arb: RTL and testbench



---
 rtl/mcpu_mem_pkg.sv | 19 +
 rtl/mcpu_mem_tagfifo.sv | 72 +++++++
 rtl/mcpu_mem_wrr_arb.sv | 185 ++++++++++++++++++
 tb/tb_mcpu_mem_wrr_arb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_mem_pkg.sv
// Shared memory-interface widths, opcodes and small helpers for the CPU-side
// memory clients and the arbiter in front of the LTC.
package mcpu_mem_pkg;

   localparam int MEM_ADDR_W = 27;   // address bits [31:5]
   localparam int MEM_DATA_W = 256;
   localparam int MEM_BE_W   = 32;

   typedef enum logic [2:0] {
      MEM_OP_READ  = 3'b001,
      MEM_OP_WRITE = 3'b010
   } mem_op_e;

   // Only reads produce a response; every other opcode is posted.
   function automatic logic is_read(input logic [2:0] op);
      return op == MEM_OP_READ;
   endfunction

endpackage

// File: rtl/mcpu_mem_tagfifo.sv
// In-order tag queue: remembers which client issued each outstanding LTC
// read so the response can be steered back. Head is visible combinationally
// so read data can be routed with zero latency.
module mcpu_mem_tagfifo #(
   parameter int QDEPTH = 8,
   parameter int TAG_W  = 2,
   parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [TAG_W-1:0] push_tag,
   input  logic             pop,
   output logic [TAG_W-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   logic [TAG_W-1:0] mem_q [QDEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(QDEPTH));
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   // A pop frees the head slot in the same cycle, so push is legal when full.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Next pointers and occupancy; simultaneous push/pop leaves count alone.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Tag storage; contents are meaningless while the slot is unoccupied.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_tag;
   end

endmodule

// File: rtl/mcpu_mem_wrr_arb.sv
// N-client memory arbiter in front of the LTC: fixed-priority or weighted
// round-robin selection, one registered request stage, and a read-tag queue
// that steers LTC read data back to the client that issued the read.
module mcpu_mem_wrr_arb
   import mcpu_mem_pkg::*;
#(
   parameter int CLIENTS      = 3,
   parameter int CLIENTS_BITS = 2,
   parameter int QDEPTH       = 8,
   parameter int WEIGHT_BITS  = 4
) (
   input  logic                          clkrst_mem_clk,
   input  logic                          clkrst_mem_rst,
   input  logic                          cfg_wrr_en,
   input  logic [WEIGHT_BITS*CLIENTS-1:0] cfg_weight,
   input  logic [CLIENTS-1:0]            cli2arb_valid,
   input  logic [3*CLIENTS-1:0]          cli2arb_opcode,
   input  logic [MEM_ADDR_W*CLIENTS-1:0] cli2arb_addr,
   input  logic [MEM_DATA_W*CLIENTS-1:0] cli2arb_wdata,
   input  logic [MEM_BE_W*CLIENTS-1:0]   cli2arb_wbe,
   output logic [CLIENTS-1:0]            cli2arb_stall,
   output logic [MEM_DATA_W-1:0]         cli2arb_rdata,
   output logic [CLIENTS-1:0]            cli2arb_rvalid,
   output logic                          arb2ltc_valid,
   output logic [2:0]                    arb2ltc_opcode,
   output logic [31:5]                   arb2ltc_addr,
   output logic [MEM_DATA_W-1:0]         arb2ltc_wdata,
   output logic [MEM_BE_W-1:0]           arb2ltc_wbe,
   input  logic                          arb2ltc_stall,
   input  logic [MEM_DATA_W-1:0]         arb2ltc_rdata,
   input  logic                          arb2ltc_rvalid,
   output logic                          arb_err
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam logic [WEIGHT_BITS-1:0] W_ONE = WEIGHT_BITS'(1);

   logic [2:0]             cli_op     [CLIENTS];
   logic [MEM_ADDR_W-1:0]  cli_addr   [CLIENTS];
   logic [MEM_DATA_W-1:0]  cli_wdata  [CLIENTS];
   logic [MEM_BE_W-1:0]    cli_wbe    [CLIENTS];
   logic [WEIGHT_BITS-1:0] weight_eff [CLIENTS];
   logic [CLIENTS-1:0]     elig, grant_vec;

   logic [CLIENTS_BITS-1:0] rr_q, rr_d, start_idx, win_idx, win_next;
   logic [WEIGHT_BITS-1:0]  credit_q, credit_d;
   logic                    win_found, grant_vld, out_free;
   int                      cand;

   logic                    valid_q, valid_d;
   logic [2:0]              op_q, op_d;
   logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
   logic [MEM_DATA_W-1:0]   wdata_q, wdata_d;
   logic [MEM_BE_W-1:0]     wbe_q, wbe_d;
   logic                    err_q, err_d;

   logic [CLIENTS_BITS-1:0] q_head;
   logic [CNT_W-1:0]        q_count;
   logic                    q_full, q_empty, q_room, tag_push, rsp_hit;

   // Reads need a free tag slot (registered count); other ops never wait on it.
   assign q_room   = (q_count < CNT_W'(QDEPTH));
   assign rsp_hit  = arb2ltc_rvalid && !q_empty;
   assign out_free = !valid_q || !arb2ltc_stall;
   // No grant while reset is held, so stalls simply mirror valids then.
   assign grant_vld = win_found && out_free && !clkrst_mem_rst;
   assign tag_push  = grant_vld && is_read(cli_op[win_idx]) && !q_full;

   for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_cli
      assign cli_op[gi]    = cli2arb_opcode[3*gi +: 3];
      assign cli_addr[gi]  = cli2arb_addr[MEM_ADDR_W*gi +: MEM_ADDR_W];
      assign cli_wdata[gi] = cli2arb_wdata[MEM_DATA_W*gi +: MEM_DATA_W];
      assign cli_wbe[gi]   = cli2arb_wbe[MEM_BE_W*gi +: MEM_BE_W];
      assign weight_eff[gi] = (cfg_weight[WEIGHT_BITS*gi +: WEIGHT_BITS] == '0)
                              ? W_ONE : cfg_weight[WEIGHT_BITS*gi +: WEIGHT_BITS];
      assign elig[gi]      = cli2arb_valid[gi] && (!is_read(cli_op[gi]) || q_room);
      assign grant_vec[gi] = grant_vld && (win_idx == CLIENTS_BITS'(gi));
      assign cli2arb_stall[gi]  = cli2arb_valid[gi] && !grant_vec[gi];
      assign cli2arb_rvalid[gi] = rsp_hit && (q_head == CLIENTS_BITS'(gi));
   end

   assign cli2arb_rdata = arb2ltc_rdata;
   assign start_idx     = cfg_wrr_en ? rr_q : '0;
   assign win_next      = (win_idx == CLIENTS_BITS'(CLIENTS - 1)) ? '0 : win_idx + 1'b1;

   // Circular search from the start index for the first eligible client.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 0; k < CLIENTS; k++) begin
         cand = int'(start_idx) + k;
         if (cand >= CLIENTS) cand = cand - CLIENTS;
         if (!win_found && elig[CLIENTS_BITS'(cand)]) begin
            win_found = 1'b1;
            win_idx   = CLIENTS_BITS'(cand);
         end
      end
   end

   // WRR bookkeeping: credit counts the grants still owed to the pointed
   // client; the last grant of a burst moves the pointer past it.
   always_comb begin
      rr_d     = rr_q;
      credit_d = credit_q;
      if (grant_vld && cfg_wrr_en) begin
         if (win_idx == rr_q && credit_q > W_ONE) begin
            credit_d = credit_q - W_ONE;
         end else if (win_idx == rr_q && credit_q == W_ONE) begin
            rr_d     = win_next;
            credit_d = '0;
         end else if (weight_eff[win_idx] > W_ONE) begin
            rr_d     = win_idx;
            credit_d = weight_eff[win_idx] - W_ONE;
         end else begin
            rr_d     = win_next;
            credit_d = '0;
         end
      end
   end

   // Output stage: load on grant, hold under stall, drop valid when drained.
   always_comb begin
      valid_d = valid_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wbe_d   = wbe_q;
      if (out_free) valid_d = grant_vld;
      if (grant_vld) begin
         op_d    = cli_op[win_idx];
         addr_d  = cli_addr[win_idx];
         wdata_d = cli_wdata[win_idx];
         wbe_d   = cli_wbe[win_idx];
      end
      err_d = err_q || (arb2ltc_rvalid && q_empty);
   end

   // State registers for arbitration, request stage and sticky error.
   always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
      if (clkrst_mem_rst) begin
         rr_q     <= '0;
         credit_q <= '0;
         valid_q  <= 1'b0;
         op_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wbe_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_q     <= rr_d;
         credit_q <= credit_d;
         valid_q  <= valid_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wbe_q    <= wbe_d;
         err_q    <= err_d;
      end
   end

   assign arb2ltc_valid  = valid_q;
   assign arb2ltc_opcode = op_q;
   assign arb2ltc_addr   = addr_q;
   assign arb2ltc_wdata  = wdata_q;
   assign arb2ltc_wbe    = wbe_q;
   assign arb_err        = err_q;

   mcpu_mem_tagfifo #(
      .QDEPTH (QDEPTH),
      .TAG_W  (CLIENTS_BITS),
      .CNT_W  (CNT_W)
   ) u_tagfifo (
      .clk      (clkrst_mem_clk),
      .rst      (clkrst_mem_rst),
      .push     (tag_push),
      .push_tag (win_idx),
      .pop      (rsp_hit),
      .head     (q_head),
      .count    (q_count),
      .full     (q_full),
      .empty    (q_empty)
   );

endmodule

// File: tb/tb_mcpu_mem_wrr_arb.sv
// Self-checking bench for mcpu_mem_wrr_arb: table of fixed-priority vectors,
// directed multi-cycle sequences, then randomized traffic against a
// transaction-level reference model.
module tb_mcpu_mem_wrr_arb;
   import mcpu_mem_pkg::*;

   localparam int NC = 3;
   localparam int CB = 2;
   localparam int QD = 8;
   localparam int WB = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              wrr_en;
   logic [WB*NC-1:0]  weight;
   logic [NC-1:0]     cvalid;
   logic [3*NC-1:0]   cop;
   logic [27*NC-1:0]  caddr;
   logic [256*NC-1:0] cwdata;
   logic [32*NC-1:0]  cwbe;
   logic [NC-1:0]     stall, rvalid;
   logic [255:0]      crdata;
   logic              ltc_valid;
   logic [2:0]        ltc_op;
   logic [31:5]       ltc_addr;
   logic [255:0]      ltc_wdata;
   logic [31:0]       ltc_wbe;
   logic              ltc_stall;
   logic [255:0]      ltc_rdata;
   logic              ltc_rvalid;
   logic              err;

   always #5 clk = ~clk;

   mcpu_mem_wrr_arb #(.CLIENTS(NC), .CLIENTS_BITS(CB), .QDEPTH(QD), .WEIGHT_BITS(WB)) dut (
      .clkrst_mem_clk (clk),
      .clkrst_mem_rst (rst),
      .cfg_wrr_en     (wrr_en),
      .cfg_weight     (weight),
      .cli2arb_valid  (cvalid),
      .cli2arb_opcode (cop),
      .cli2arb_addr   (caddr),
      .cli2arb_wdata  (cwdata),
      .cli2arb_wbe    (cwbe),
      .cli2arb_stall  (stall),
      .cli2arb_rdata  (crdata),
      .cli2arb_rvalid (rvalid),
      .arb2ltc_valid  (ltc_valid),
      .arb2ltc_opcode (ltc_op),
      .arb2ltc_addr   (ltc_addr),
      .arb2ltc_wdata  (ltc_wdata),
      .arb2ltc_wbe    (ltc_wbe),
      .arb2ltc_stall  (ltc_stall),
      .arb2ltc_rdata  (ltc_rdata),
      .arb2ltc_rvalid (ltc_rvalid),
      .arb_err        (err)
   );

   int errs = 0;
   int checks = 0;

   // Reference model: what the LTC port should hold, the outstanding read
   // owners in issue order, and the WRR burst position.
   bit           m_valid;
   logic [2:0]   m_op;
   logic [26:0]  m_addr;
   logic [255:0] m_wdata;
   logic [31:0]  m_wbe;
   bit           m_err;
   int           q[$];
   int           m_ptr;
   int           m_left;
   int           cur_w;

   typedef struct {
      logic [2:0] valid;
      logic [2:0] exp_stall;
   } vec_t;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
      return v;
   endfunction

   function automatic int model_winner();
      int c;
      if (rst) return -1;
      if (m_valid && ltc_stall) return -1;
      for (int k = 0; k < NC; k++) begin
         c = wrr_en ? (m_ptr + k) % NC : k;
         if (cvalid[c] && (cop[c*3 +: 3] != MEM_OP_READ || q.size() < QD)) return c;
      end
      return -1;
   endfunction

   function automatic int obs_grant();
      for (int i = 0; i < NC; i++) if (cvalid[i] && !stall[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_op = '0; m_addr = '0; m_wdata = '0; m_wbe = '0;
      m_err = 1'b0; q.delete(); m_ptr = 0; m_left = 0;
   endtask

   // Compare every DUT output against the model mid-cycle.
   task automatic sample();
      logic [NC-1:0] es, er;
      @(negedge clk);
      cur_w = model_winner();
      es = '0;
      er = '0;
      for (int i = 0; i < NC; i++) es[i] = cvalid[i] && (cur_w != i);
      if (!rst && ltc_rvalid && q.size() > 0) er[q[0]] = 1'b1;
      chk("stall", stall, es);
      chk("rvalid", rvalid, er);
      if (er != '0) chk("rdata", crdata, ltc_rdata);
      chk("ltc_valid", ltc_valid, m_valid);
      chk("ltc_op", ltc_op, m_op);
      chk("ltc_addr", ltc_addr, m_addr);
      chk("ltc_wdata", ltc_wdata, m_wdata);
      chk("ltc_wbe", ltc_wbe, m_wbe);
      chk("arb_err", err, m_err);
   endtask

   // Advance the model across the clock edge, then release inputs.
   task automatic tick();
      bit free;
      int weff;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         free = !m_valid || !ltc_stall;
         if (ltc_rvalid) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_err = 1'b1;
         end
         if (cur_w >= 0) begin
            m_valid = 1'b1;
            m_op    = cop[cur_w*3 +: 3];
            m_addr  = caddr[cur_w*27 +: 27];
            m_wdata = cwdata[cur_w*256 +: 256];
            m_wbe   = cwbe[cur_w*32 +: 32];
            if (m_op == MEM_OP_READ) q.push_back(cur_w);
            if (wrr_en) begin
               weff = int'(weight[cur_w*WB +: WB]);
               if (weff == 0) weff = 1;
               if (cur_w == m_ptr && m_left > 0) begin
                  m_left--;
                  if (m_left == 0) m_ptr = (cur_w + 1) % NC;
               end else begin
                  m_left = weff - 1;
                  m_ptr  = (m_left > 0) ? cur_w : (cur_w + 1) % NC;
               end
            end
         end else if (free) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic cyc();
      sample();
      tick();
   endtask

   task automatic set_client(input int c, input bit v, input logic [2:0] op, input logic [26:0] a);
      cvalid[c]           = v;
      cop[c*3 +: 3]       = op;
      caddr[c*27 +: 27]   = a;
      cwdata[c*256 +: 256] = rand256();
      cwbe[c*32 +: 32]    = $urandom();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t         tbl[8];
      logic [2:0]   ops[4];
      int           pat[6];
      int           cnt[NC];
      int           g;
      logic [26:0]  hold_addr;
      logic [2:0]   rv_exp[6];
      int           rd_order[3];

      rst = 1'b1; wrr_en = 1'b0; weight = {4'd3, 4'd2, 4'd1};
      cvalid = '0; cop = '0; caddr = '0; cwdata = '0; cwbe = '0;
      ltc_stall = 1'b0; ltc_rdata = '0; ltc_rvalid = 1'b0;
      model_reset();
      #2;
      // Reset state: request stage and error cleared, stall mirrors valid.
      set_client(1, 1'b1, MEM_OP_WRITE, 27'h5);
      sample();
      chk("rst_valid", ltc_valid, 1'b0);
      chk("rst_addr", ltc_addr, 27'h0);
      chk("rst_stall", stall, 3'b010);
      tick();
      do_reset();

      // Fixed-priority vectors, writes only, output stage never stalled.
      tbl[0] = '{3'b000, 3'b000}; tbl[1] = '{3'b001, 3'b000};
      tbl[2] = '{3'b010, 3'b000}; tbl[3] = '{3'b011, 3'b010};
      tbl[4] = '{3'b100, 3'b000}; tbl[5] = '{3'b101, 3'b100};
      tbl[6] = '{3'b110, 3'b100}; tbl[7] = '{3'b111, 3'b110};
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < NC; c++) set_client(c, tbl[r].valid[c], MEM_OP_WRITE, 27'(16*r + c));
         sample();
         chk("tbl_stall", stall, tbl[r].exp_stall);
         tick();
      end

      // 1: fixed priority, clients 0 and 2 writing continuously.
      set_client(0, 1'b1, MEM_OP_WRITE, 27'h100);
      set_client(1, 1'b0, MEM_OP_WRITE, 27'h101);
      set_client(2, 1'b1, MEM_OP_WRITE, 27'h102);
      for (int k = 0; k < 10; k++) begin
         sample();
         chk("fix_stall", stall, 3'b100);
         if (k > 0) chk("fix_addr", ltc_addr, 27'h100);
         tick();
      end

      // 2: WRR weights {1,2,3}, all clients always valid.
      wrr_en = 1'b1;
      weight = {4'd3, 4'd2, 4'd1};
      for (int c = 0; c < NC; c++) set_client(c, 1'b1, MEM_OP_WRITE, 27'(c));
      do_reset();
      pat[0] = 0; pat[1] = 1; pat[2] = 1; pat[3] = 2; pat[4] = 2; pat[5] = 2;
      for (int c = 0; c < NC; c++) cnt[c] = 0;
      for (int k = 0; k < 60; k++) begin
         sample();
         g = obs_grant();
         chk("wrr_order", 256'(g), 256'(pat[k % 6]));
         if (g >= 0) cnt[g]++;
         tick();
      end
      chk("wrr_share0", 256'(cnt[0]), 256'd10);
      chk("wrr_share1", 256'(cnt[1]), 256'd20);
      chk("wrr_share2", 256'(cnt[2]), 256'd30);

      // 3: downstream stall for 5 cycles holds the payload.
      ltc_stall = 1'b1;
      hold_addr = m_addr;
      for (int k = 0; k < 5; k++) begin
         sample();
         chk("hold_stall", stall, 3'b111);
         chk("hold_valid", ltc_valid, 1'b1);
         chk("hold_addr", ltc_addr, hold_addr);
         tick();
      end
      ltc_stall = 1'b0;
      sample();
      chk("resume_grant", 256'((cvalid & ~stall) != '0), 256'd1);
      tick();

      // 4: queue full blocks reads but not writes; one response frees a slot.
      wrr_en = 1'b0;
      cvalid = '0;
      do_reset();
      for (int k = 0; k < QD; k++) begin
         set_client(1, 1'b1, MEM_OP_READ, 27'(32'h200 + k));
         sample();
         chk("qf_fill", stall, 3'b000);
         tick();
      end
      set_client(1, 1'b1, MEM_OP_READ, 27'h2ff);
      sample();
      chk("qf_block", stall, 3'b010);
      tick();
      set_client(0, 1'b1, MEM_OP_WRITE, 27'h300);
      sample();
      chk("qf_write", stall, 3'b010);
      tick();
      cvalid[0] = 1'b0;
      ltc_rvalid = 1'b1;
      ltc_rdata  = rand256();
      sample();
      chk("qf_rvalid", rvalid, 3'b010);
      chk("qf_still", stall, 3'b010);
      tick();
      ltc_rvalid = 1'b0;
      sample();
      chk("qf_unblock", stall, 3'b000);
      tick();
      cvalid = '0;
      for (int k = 0; k < QD; k++) begin
         ltc_rvalid = 1'b1;
         ltc_rdata  = rand256();
         cyc();
      end
      ltc_rvalid = 1'b0;

      // 5: ordering 2,0,1 with responses overlapping new pushes.
      do_reset();
      rd_order[0] = 2; rd_order[1] = 0; rd_order[2] = 1;
      for (int j = 0; j < 3; j++) begin
         cvalid = '0;
         set_client(rd_order[j], 1'b1, MEM_OP_READ, 27'(32'h400 + j));
         cyc();
      end
      rv_exp[0] = 3'b100; rv_exp[1] = 3'b001; rv_exp[2] = 3'b010;
      rv_exp[3] = 3'b100; rv_exp[4] = 3'b001; rv_exp[5] = 3'b010;
      for (int j = 0; j < 6; j++) begin
         cvalid = '0;
         if (j < 3) set_client(rd_order[j], 1'b1, MEM_OP_READ, 27'(32'h500 + j));
         ltc_rvalid = 1'b1;
         ltc_rdata  = rand256();
         sample();
         chk("ord_rvalid", rvalid, rv_exp[j]);
         tick();
      end
      ltc_rvalid = 1'b0;
      cvalid = '0;

      // 6: reset with reads in flight; a late response is dropped and flagged.
      do_reset();
      for (int j = 0; j < 3; j++) begin
         cvalid = '0;
         set_client(j, 1'b1, MEM_OP_READ, 27'(32'h600 + j));
         cyc();
      end
      cvalid = '0;
      do_reset();
      ltc_rvalid = 1'b1;
      sample();
      chk("rst_rvalid", rvalid, 3'b000);
      tick();
      ltc_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("rst_err", err, 1'b1);
         tick();
      end
      do_reset();
      sample();
      chk("rst_err_clr", err, 1'b0);
      tick();

      // Randomized traffic against the model.
      ops[0] = MEM_OP_READ; ops[1] = MEM_OP_WRITE; ops[2] = 3'b000; ops[3] = 3'b111;
      for (int n = 0; n < 1500; n++) begin
         if (n % 200 == 0) begin
            wrr_en = 1'($urandom_range(0, 1));
            for (int c = 0; c < NC; c++) weight[c*WB +: WB] = 4'($urandom_range(0, 4));
         end
         if (n == 800) do_reset();
         for (int c = 0; c < NC; c++)
            set_client(c, $urandom_range(0, 3) != 0, ops[$urandom_range(0, 3)], 27'($urandom()));
         ltc_stall  = ($urandom_range(0, 3) == 0);
         ltc_rvalid = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 60) == 0);
         ltc_rdata  = rand256();
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
